// File: rtl/i2s_slave_rx_pkg.sv
// Shared I2S definitions plus the word-length and justification helpers used by the receiver.
package i2s_slave_rx_pkg;

  localparam logic I2S_CHL_16_BITS = 1'b0;
  localparam logic I2S_CHL_32_BITS = 1'b1;
  localparam int   I2S_DATA_WIDTH  = 32;

  function automatic logic [5:0] chl_bits(input logic chl);
    return (chl == I2S_CHL_32_BITS) ? 6'd32 : 6'd16;
  endfunction

  // A word cut short by an early WS edge is moved up so its MSB sits at bit wlen-1.
  function automatic logic [31:0] left_justify(input logic [31:0] word,
                                               input logic [5:0]  nbits,
                                               input logic [5:0]  wlen);
    if (nbits < wlen) return word << (wlen - nbits);
    return word;
  endfunction

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with rise/fall pulses from one extra flop.
module i2s_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/i2s_slave_rx.sv
// I2S slave receiver: oversamples SCK/WS/SD, frames words on WS edges with the one-bit delay,
// and presents each completed word on a single-entry valid/ready register.
module i2s_slave_rx
  import i2s_slave_rx_pkg::*;
#(
  parameter int DATA_WIDTH  = I2S_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  pol_i,
  input  logic                  chl_i,
  input  logic                  sck_i,
  input  logic                  ws_i,
  input  logic                  sd_i,
  input  logic                  clr_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  ch_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  ovf_o,
  output logic                  short_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_ALIGN, ST_SHIFT, ST_HOLD} state_e;

  logic sck_s, sck_rise, sck_fall;
  logic ws_s, ws_rise, ws_fall;
  logic sd_s, sd_rise, sd_fall;

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(sck_i),
    .level_o(sck_s), .rise_o(sck_rise), .fall_o(sck_fall));
  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ws (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(ws_i),
    .level_o(ws_s), .rise_o(ws_rise), .fall_o(ws_fall));
  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sd (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(sd_i),
    .level_o(sd_s), .rise_o(sd_rise), .fall_o(sd_fall));

  logic unused_edges;
  assign unused_edges = ^{sck_s, ws_rise, ws_fall, sd_rise, sd_fall};

  state_e          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [31:0]     shift_q, shift_d;
  logic            ws_prev_q, ws_prev_d;
  logic            cur_ch_q, cur_ch_d;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic            ch_q, ch_d;
  logic            valid_q, valid_d;
  logic            ovf_q, ovf_d;
  logic            short_q, short_d;

  logic            sample, ws_chg, emit;
  logic [5:0]      wlen, word_cnt;
  logic [31:0]     word_full;

  assign wlen   = chl_bits(chl_i);
  assign sample = pol_i ? sck_fall : sck_rise;
  assign ws_chg = sample && (ws_s != ws_prev_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    ws_prev_d = ws_prev_q;
    cur_ch_d  = cur_ch_q;
    emit      = 1'b0;
    word_full = shift_q;
    word_cnt  = cnt_q;
    if (sample) ws_prev_d = ws_s;
    if (!en_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      shift_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d   = ST_ALIGN;
          ws_prev_d = ws_s;
        end
        ST_ALIGN: begin
          if (ws_chg) begin
            cur_ch_d = ws_s;
            cnt_d    = '0;
            shift_d  = '0;
            state_d  = ST_SHIFT;
          end
        end
        ST_SHIFT, ST_HOLD: begin
          if (ws_chg) begin
            // The bit on the WS edge is the previous word's LSB (one-bit I2S delay).
            if (cnt_q < wlen) begin
              word_full = {shift_q[30:0], sd_s};
              word_cnt  = cnt_q + 6'd1;
            end
            emit     = 1'b1;
            cnt_d    = '0;
            shift_d  = '0;
            cur_ch_d = ws_s;
            state_d  = ST_SHIFT;
          end else if (sample && (state_q == ST_SHIFT) && (cnt_q < wlen)) begin
            shift_d = {shift_q[30:0], sd_s};
            cnt_d   = cnt_q + 6'd1;
            if (cnt_q + 6'd1 == wlen) state_d = ST_HOLD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    short_d = short_q;
    if (clr_i) ovf_d = 1'b0;
    if (emit) begin
      if (!valid_q || ready_i) begin
        data_d  = DATA_WIDTH'(left_justify(word_full, word_cnt, wlen));
        ch_d    = cur_ch_q;
        short_d = (word_cnt < wlen);
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      ws_prev_q <= 1'b0;
      cur_ch_q  <= 1'b0;
      data_q    <= '0;
      ch_q      <= 1'b0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      short_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      ws_prev_q <= ws_prev_d;
      cur_ch_q  <= cur_ch_d;
      data_q    <= data_d;
      ch_q      <= ch_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      short_q   <= short_d;
    end
  end

  assign data_o  = data_q;
  assign ch_o    = ch_q;
  assign valid_o = valid_q;
  assign ovf_o   = ovf_q;
  assign short_o = short_q;

endmodule

// File: tb/tb_i2s_slave_rx.sv
// Bench for i2s_slave_rx: an I2S master BFM drives framed word lists; a word-level model predicts emitted words.
module tb_i2s_slave_rx;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_i = 1'b0;
  logic        pol_i = 1'b0;
  logic        chl_i = 1'b1;
  logic        sck_i = 1'b0;
  logic        ws_i = 1'b0;
  logic        sd_i = 1'b0;
  logic        clr_i = 1'b0;
  logic        ready_i = 1'b0;
  logic [31:0] data_o;
  logic        ch_o, valid_o, ovf_o, short_o;

  always #5 clk = ~clk;

  i2s_slave_rx #(.DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .pol_i(pol_i), .chl_i(chl_i),
    .sck_i(sck_i), .ws_i(ws_i), .sd_i(sd_i), .clr_i(clr_i),
    .data_o(data_o), .ch_o(ch_o), .valid_o(valid_o), .ready_i(ready_i),
    .ovf_o(ovf_o), .short_o(short_o));

  typedef struct { bit ch; logic [63:0] data; int n; } word_t;
  typedef struct { logic [31:0] d; bit ch; bit sh; } exp_t;

  word_t wl[$];
  exp_t  eq[$];
  int    vectors = 0;
  int    miscompares = 0;
  bit    chk_en = 1'b0;
  bit    rdy_rand = 1'b0;
  bit    rdy_fixed = 1'b1;
  bit    saw_ovf = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    ready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fixed;
  end

  always @(negedge clk) if (ovf_o) saw_ovf = 1'b1;

  // Every cycle a word is presented it must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (chk_en && valid_o && !rst_i) begin
      if (eq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_word: got data %h ch %0d, expected no word", data_o, ch_o);
      end else begin
        chk("word_data", data_o, eq[0].d);
        chk("word_ch", ch_o, eq[0].ch);
        chk("word_short", short_o, eq[0].sh);
        if (ready_i) void'(eq.pop_front());
      end
    end
  end

  function automatic exp_t exp_word(input word_t w, input int wbits);
    exp_t e;
    logic [63:0] v;
    if (w.n < wbits) begin
      v = (w.data & ((64'd1 << w.n) - 64'd1)) << (wbits - w.n);
      e.sh = 1'b1;
    end else begin
      v = (w.data >> (w.n - wbits)) & ((64'd1 << wbits) - 64'd1);
      e.sh = 1'b0;
    end
    e.d  = v[31:0];
    e.ch = w.ch;
    return e;
  endfunction

  // Only words bounded by a WS change on both sides are received; the first is the alignment frame.
  task automatic model_list(input int wbits);
    for (int k = 1; k + 1 < wl.size(); k++) eq.push_back(exp_word(wl[k], wbits));
  endtask

  task automatic add_word(input bit ch, input logic [63:0] data, input int n);
    word_t w;
    w.ch = ch; w.data = data; w.n = n;
    wl.push_back(w);
  endtask

  task automatic push_exp(input logic [31:0] d, input bit ch, input bit sh);
    exp_t e;
    e.d = d; e.ch = ch; e.sh = sh;
    eq.push_back(e);
  endtask

  task automatic start(input bit pol, input bit chl, input bit first_ch);
    @(negedge clk);
    en_i = 1'b0;
    repeat (4) @(negedge clk);
    pol_i = pol; chl_i = chl; sck_i = pol; ws_i = first_ch; sd_i = 1'b0;
    repeat (10) @(negedge clk);
    en_i = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // WS leads the data by one bit: each bit carries the channel of the bit after it.
  task automatic send_list();
    bit bch[$];
    bit bsd[$];
    foreach (wl[k])
      for (int i = wl[k].n - 1; i >= 0; i--) begin
        bch.push_back(wl[k].ch);
        bsd.push_back(wl[k].data[i]);
      end
    for (int j = 0; j < bch.size(); j++) begin
      sck_i = pol_i;
      ws_i  = (j + 1 < bch.size()) ? bch[j + 1] : bch[j];
      sd_i  = bsd[j];
      repeat (4) @(negedge clk);
      sck_i = ~pol_i;
      repeat (4) @(negedge clk);
    end
    sck_i = pol_i;
    repeat (12) @(negedge clk);
    wl.delete();
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((eq.size() != 0 || valid_o) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d words outstanding, expected 0", eq.size());
      eq.delete();
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_ch", ch_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_short", short_o, 0);
    rst_i = 1'b0;

    // 32-bit, rising-edge sampling
    chk_en = 1'b1; rdy_fixed = 1'b1;
    start(1'b0, 1'b1, 1'b1);
    add_word(1, 64'hDEADBEEF, 32); add_word(0, 64'hA5A50F0F, 32);
    add_word(1, 64'h12345678, 32); add_word(0, 64'h0BADF00D, 32);
    push_exp(32'hA5A50F0F, 0, 0); push_exp(32'h12345678, 1, 0);
    send_list();
    wait_drain();

    // 16-bit, falling-edge sampling
    start(1'b1, 1'b0, 1'b1);
    add_word(1, 64'hAAAA, 16); add_word(0, 64'hBEEF, 16);
    add_word(1, 64'h0001, 16); add_word(0, 64'h5555, 16);
    push_exp(32'h0000BEEF, 0, 0); push_exp(32'h00000001, 1, 0);
    send_list();
    wait_drain();

    // short and long words
    start(1'b0, 1'b1, 1'b1);
    add_word(1, 64'h0, 32); add_word(0, 64'hFFFFF, 20);
    add_word(1, 64'h123456789A, 40); add_word(0, 64'hFFFFFFFF, 32);
    push_exp(32'hFFFFF000, 0, 1); push_exp(32'h12345678, 1, 0);
    send_list();
    wait_drain();

    // backpressure and overflow
    chk_en = 1'b0; rdy_fixed = 1'b0;
    start(1'b0, 1'b1, 1'b1);
    add_word(1, 64'h0, 32); add_word(0, 64'h11111111, 32);
    add_word(1, 64'h22222222, 32); add_word(0, 64'h0, 32);
    send_list();
    chk("bp_valid", valid_o, 1);
    chk("bp_data", data_o, 32'h11111111);
    chk("bp_ch", ch_o, 0);
    chk("bp_ovf", ovf_o, 1);
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    @(negedge clk);
    chk("clr_ovf", ovf_o, 0);
    chk("clr_keeps_word", data_o, 32'h11111111);
    rdy_fixed = 1'b1;
    repeat (3) @(negedge clk);
    rdy_fixed = 1'b0;
    repeat (2) @(negedge clk);
    chk("accept_valid", valid_o, 0);

    // a clear held across the overflow must not mask it
    clr_i = 1'b1;
    start(1'b0, 1'b1, 1'b1);
    saw_ovf = 1'b0;
    add_word(1, 64'h0, 32); add_word(0, 64'h33333333, 32);
    add_word(1, 64'h44444444, 32); add_word(0, 64'h0, 32);
    send_list();
    chk("ovf_beats_clr", saw_ovf, 1);
    chk("ovf_after_clr", ovf_o, 0);
    chk("held_word", data_o, 32'h33333333);
    clr_i = 1'b0;
    rdy_fixed = 1'b1;
    repeat (4) @(negedge clk);

    // disable mid-word, then re-enable
    chk_en = 1'b1; rdy_rand = 1'b1;
    start(1'b0, 1'b1, 1'b1);
    add_word(1, 64'h0, 32); add_word(0, 64'h3FF, 10);
    send_list();
    en_i = 1'b0;
    repeat (20) @(negedge clk);
    chk("endrop_valid", valid_o, 0);
    start(1'b0, 1'b1, 1'b0);
    add_word(0, 64'h0, 32); add_word(1, 64'hCAFEF00D, 32);
    add_word(0, 64'h600DCAFE, 32); add_word(1, 64'h0, 32);
    push_exp(32'hCAFEF00D, 1, 0); push_exp(32'h600DCAFE, 0, 0);
    send_list();
    wait_drain();

    // randomized frames against the word model
    for (int r = 0; r < 6; r++) begin
      bit pol, chl, ch;
      int wb, nw, n, kind;
      pol = 1'($urandom); chl = 1'($urandom); ch = 1'($urandom);
      wb = chl ? 32 : 16;
      nw = $urandom_range(5, 8);
      start(pol, chl, ch);
      for (int k = 0; k < nw; k++) begin
        kind = $urandom_range(0, 4);
        if (kind == 3) n = $urandom_range(1, wb - 1);
        else if (kind == 4) n = wb + $urandom_range(1, 8);
        else n = wb;
        add_word(ch, {$urandom, $urandom}, n);
        ch = ~ch;
      end
      model_list(wb);
      send_list();
      wait_drain();
    end

    // reset mid-word with a word held and an overflow pending
    chk_en = 1'b0; rdy_rand = 1'b0; rdy_fixed = 1'b0;
    start(1'b0, 1'b1, 1'b0);
    add_word(0, 64'h0, 32); add_word(1, 64'h77777777, 32);
    add_word(0, 64'h88888888, 32); add_word(1, 64'hFFF, 12);
    send_list();
    chk("pre_rst_valid", valid_o, 1);
    chk("pre_rst_ovf", ovf_o, 1);
    chk("pre_rst_ch", ch_o, 1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("midrst_valid", valid_o, 0);
    chk("midrst_data", data_o, 0);
    chk("midrst_ovf", ovf_o, 0);
    chk("midrst_ch", ch_o, 0);
    chk("midrst_short", short_o, 0);

    chk("model_queue_empty", eq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
